// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - byte delivery interface between uart_rx and its consumer
interface uart_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       rx_frame_err;
   logic       rx_parity_err;
   logic       rx_break;
   logic       rx_overrun;
   logic       rx_busy;

   modport master (
      output rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_break, rx_overrun, rx_busy,
      input  rx_ready
   );

   modport slave (
      input  rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_break, rx_overrun, rx_busy,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8-bit LSB-first UART receiver with optional parity and valid/ready output
module uart_rx #(
   parameter int CLK_HZ = 100000000,
   parameter int BAUD   = 115200,
   parameter int PARITY = 0
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     rxd,
   uart_rx_if.master rx
);
   localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] HALF_RELOAD = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_RELOAD = CW'(DIV - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t        state, state_nxt;
   logic          s1, s, prev;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shreg;
   logic          par_err;
   logic          tick;
   logic          stop_tick;

   logic [7:0]    data_q;
   logic          valid_q, frame_err_q, parity_err_q, break_q, overrun_q;

   assign tick = (cnt == '0);

   // two-flop synchroniser plus a history flop for falling-edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         s1   <= 1'b1;
         s    <= 1'b1;
         prev <= 1'b1;
      end else begin
         s1   <= rxd;
         s    <= s1;
         prev <= s;
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state logic; the stop tick returns to IDLE mid-bit so back-to-back frames are caught
   always_comb begin
      state_nxt = state;
      stop_tick = 1'b0;
      case (state)
         IDLE:  if (!s && prev) state_nxt = START;
         START: if (tick) state_nxt = s ? IDLE : DATA;
         DATA:  if (tick && idx == 3'd7) state_nxt = (PARITY != 0) ? PAR : STOP;
         PAR:   if (tick) state_nxt = STOP;
         STOP: begin
            if (tick) begin
               stop_tick = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // bit timer: half a bit to the start-bit centre, then whole bits; shift register and parity check
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
         par_err <= 1'b0;
      end else begin
         if (state == IDLE) cnt <= HALF_RELOAD;
         else               cnt <= tick ? FULL_RELOAD : cnt - 1'b1;

         if (state == START) begin
            idx     <= '0;
            par_err <= 1'b0;
         end else if (state == DATA && tick) begin
            idx   <= idx + 3'd1;
            shreg <= {s, shreg[7:1]};
         end else if (state == PAR && tick) begin
            par_err <= (^{shreg, s}) ^ (PARITY == 1);
         end
      end
   end

   // output holding register: load on a free or draining slot, otherwise drop and flag overrun
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q       <= '0;
         valid_q      <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         break_q      <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (valid_q && rx.rx_ready) valid_q <= 1'b0;
         if (stop_tick) begin
            if (!valid_q || rx.rx_ready) begin
               data_q       <= shreg;
               valid_q      <= 1'b1;
               frame_err_q  <= !s;
               parity_err_q <= par_err;
               break_q      <= !s && (shreg == 8'h00);
            end else begin
               overrun_q <= 1'b1;
            end
         end
      end
   end

   assign rx.rx_data       = data_q;
   assign rx.rx_valid      = valid_q;
   assign rx.rx_frame_err  = frame_err_q;
   assign rx.rx_parity_err = parity_err_q;
   assign rx.rx_break      = break_q;
   assign rx.rx_overrun    = overrun_q;
   assign rx.rx_busy       = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;
   localparam int CLK_HZ = 1000000;
   localparam int BAUD   = 100000;
   localparam int DIV    = 10;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic rxd   = 1'b1;
   logic sel_p = 1'b0;
   logic rxd_a, rxd_p;
   int   cyc   = 0;

   uart_rx_if ifa();
   uart_rx_if ifp();

   assign rxd_a = sel_p ? 1'b1 : rxd;
   assign rxd_p = sel_p ? rxd : 1'b1;

   uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY(0)) dut_a (
      .clk(clk), .rst(rst), .rxd(rxd_a), .rx(ifa)
   );

   uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY(2)) dut_p (
      .clk(clk), .rst(rst), .rxd(rxd_p), .rx(ifp)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] d;
      logic       fe;
      logic       pe;
      logic       brk;
      int         c;
   } rec_t;

   rec_t qa[$];
   rec_t qp[$];
   int   ov_cnt    = 0;
   int   ov_cyc    = -1;
   int   busy_rise = -1;
   int   busy_fall = -1;
   logic busy_q    = 1'b0;

   always @(negedge clk) begin
      if (ifa.rx_valid && ifa.rx_ready)
         qa.push_back('{ifa.rx_data, ifa.rx_frame_err, ifa.rx_parity_err, ifa.rx_break, cyc});
      if (ifp.rx_valid && ifp.rx_ready)
         qp.push_back('{ifp.rx_data, ifp.rx_frame_err, ifp.rx_parity_err, ifp.rx_break, cyc});
      if (ifa.rx_overrun) begin
         ov_cnt = ov_cnt + 1;
         ov_cyc = cyc;
      end
      if (ifa.rx_busy && !busy_q) busy_rise = cyc;
      if (!ifa.rx_busy && busy_q) busy_fall = cyc;
      busy_q = ifa.rx_busy;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (got === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit with_par, input bit pbit,
                             input bit stop, output int e);
      e   = cyc + 2;
      rxd = 1'b0;
      tick_n(DIV);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tick_n(DIV);
      end
      if (with_par) begin
         rxd = pbit;
         tick_n(DIV);
      end
      rxd = stop;
      tick_n(DIV);
   endtask

   task automatic check_rec(input string tag, input rec_t r, input logic [7:0] d,
                            input logic fe, input logic pe, input logic brk);
      check({tag, "_data"}, 32'(r.d), 32'(d));
      check({tag, "_fe"}, 32'(r.fe), 32'(fe));
      check({tag, "_pe"}, 32'(r.pe), 32'(pe));
      check({tag, "_brk"}, 32'(r.brk), 32'(brk));
   endtask

   initial begin
      int   e, e2, e3;
      logic [7:0] b;

      ifa.rx_ready = 1'b0;
      ifp.rx_ready = 1'b1;
      @(posedge clk);
      #1;
      tick_n(3);
      check("rst_valid", 32'(ifa.rx_valid), 32'd0);
      check("rst_data", 32'(ifa.rx_data), 32'd0);
      check("rst_fe", 32'(ifa.rx_frame_err), 32'd0);
      check("rst_pe", 32'(ifa.rx_parity_err), 32'd0);
      check("rst_brk", 32'(ifa.rx_break), 32'd0);
      check("rst_ov", 32'(ifa.rx_overrun), 32'd0);
      check("rst_busy", 32'(ifa.rx_busy), 32'd0);
      rst = 1'b0;
      ifa.rx_ready = 1'b1;
      tick_n(5);

      // clean 8N1 byte with consumer always ready
      qa.delete();
      send_frame(8'h55, 0, 0, 1, e);
      tick_n(5);
      check("b55_count", 32'(qa.size()), 32'd1);
      if (qa.size() >= 1) begin
         check_rec("b55", qa[0], 8'h55, 0, 0, 0);
         check("b55_cycle", 32'(qa[0].c), 32'(e + 96));
      end
      check("b55_busy_rise", 32'(busy_rise), 32'(e + 1));
      check("b55_busy_fall", 32'(busy_fall), 32'(e + 96));
      check("b55_valid_after", 32'(ifa.rx_valid), 32'd0);
      check("b55_no_ov", 32'(ov_cnt), 32'd0);

      // glitch shorter than half a bit is rejected as a false start
      qa.delete();
      e   = cyc + 2;
      rxd = 1'b0;
      tick_n(3);
      rxd = 1'b1;
      tick_n(20);
      check("false_count", 32'(qa.size()), 32'd0);
      check("false_busy_rise", 32'(busy_rise), 32'(e + 1));
      check("false_busy_fall", 32'(busy_fall), 32'(e + 6));
      check("false_busy_now", 32'(ifa.rx_busy), 32'd0);

      // framing error, then break, then line must go high before the next frame
      qa.delete();
      send_frame(8'hA3, 0, 0, 0, e);
      rxd = 1'b1;
      tick_n(5);
      send_frame(8'h00, 0, 0, 0, e2);
      tick_n(40);
      check("brk_busy_low", 32'(ifa.rx_busy), 32'd0);
      check("brk_no_restart", 32'(busy_rise), 32'(e2 + 1));
      check("brk_count", 32'(qa.size()), 32'd2);
      if (qa.size() >= 2) begin
         check_rec("fe_a3", qa[0], 8'hA3, 1, 0, 0);
         check_rec("brk_00", qa[1], 8'h00, 1, 0, 1);
      end
      rxd = 1'b1;
      tick_n(5);
      send_frame(8'h5A, 0, 0, 1, e3);
      tick_n(5);
      check("after_brk_count", 32'(qa.size()), 32'd3);
      if (qa.size() >= 3) begin
         check_rec("after_brk", qa[2], 8'h5A, 0, 0, 0);
         check("after_brk_cycle", 32'(qa[2].c), 32'(e3 + 96));
      end

      // even parity instance
      sel_p = 1'b1;
      qa.delete();
      qp.delete();
      tick_n(5);
      send_frame(8'h07, 1, 0, 1, e);
      tick_n(5);
      check("par0_count", 32'(qp.size()), 32'd1);
      if (qp.size() >= 1) begin
         check_rec("par0", qp[0], 8'h07, 0, 1, 0);
         check("par0_cycle", 32'(qp[0].c), 32'(e + 106));
      end
      send_frame(8'h07, 1, 1, 1, e);
      tick_n(5);
      check("par1_count", 32'(qp.size()), 32'd2);
      if (qp.size() >= 2) begin
         check_rec("par1", qp[1], 8'h07, 0, 0, 0);
         check("par1_cycle", 32'(qp[1].c), 32'(e + 106));
      end
      check("par_other_idle", 32'(qa.size()), 32'd0);
      sel_p = 1'b0;
      tick_n(5);

      // overrun: consumer stalls across two back-to-back frames
      ifa.rx_ready = 1'b0;
      qa.delete();
      ov_cnt = 0;
      send_frame(8'h11, 0, 0, 1, e);
      send_frame(8'h22, 0, 0, 1, e2);
      tick_n(5);
      check("ov_count", 32'(ov_cnt), 32'd1);
      check("ov_cycle", 32'(ov_cyc), 32'(e2 + 96));
      check("ov_held_valid", 32'(ifa.rx_valid), 32'd1);
      check("ov_held_data", 32'(ifa.rx_data), 32'h11);
      ifa.rx_ready = 1'b1;
      tick_n(3);
      check("ov_drain_count", 32'(qa.size()), 32'd1);
      if (qa.size() >= 1) check("ov_drain_data", 32'(qa[0].d), 32'h11);
      check("ov_valid_clear", 32'(ifa.rx_valid), 32'd0);

      // reset during bit 4 aborts the frame; the sender also abandons it
      qa.delete();
      b   = 8'h3C;
      rxd = 1'b0;
      tick_n(DIV);
      for (int i = 0; i < 4; i++) begin
         rxd = b[i];
         tick_n(DIV);
      end
      rxd = b[4];
      tick_n(3);
      rst = 1'b1;
      tick_n(1);
      rst = 1'b0;
      check("abort_busy", 32'(ifa.rx_busy), 32'd0);
      rxd = 1'b1;
      tick_n(80);
      check("abort_count", 32'(qa.size()), 32'd0);
      check("abort_valid", 32'(ifa.rx_valid), 32'd0);
      send_frame(8'h3C, 0, 0, 1, e);
      tick_n(5);
      check("b3c_count", 32'(qa.size()), 32'd1);
      if (qa.size() >= 1) begin
         check_rec("b3c", qa[0], 8'h3C, 0, 0, 0);
         check("b3c_cycle", 32'(qa[0].c), 32'(e + 96));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
